eth_fcs_seq: RTL and testbench
==============================

// Module: eth_fcs_seq
// PURPOSE
//  Transmit-side FCS sequencer for the Ethernet MAC. Accepts frame bytes on a valid/ready stream,
//  runs them through the reflected CRC-32 byte step, and forwards them to the PHY-side stream.
//  Appends the 4-byte FCS after the last byte, then enforces the inter-frame gap.
//  Sits between the TX frame buffer and the GMII byte serializer.
// PARAMETERS
//  IFG_CYCLES   12   idle cycles after the last FCS byte before the next frame is accepted (>=1)
//  MIN_PAYLOAD  60   minimum bytes before FCS; used only with ETH_FCS_PAD_EN
//  CNT_W        16   width of byte counter and frame counter
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  s_data     in   8      frame byte from buffer
//  s_valid    in   1      s_data valid
//  s_last     in   1      s_data is the final payload byte of the frame
//  s_ready    out  1      block accepts s_data this cycle
//  m_data     out  8      byte to serializer (payload, pad or FCS)
//  m_valid    out  1      m_data valid
//  m_last     out  1      m_data is the final FCS byte
//  m_ready    in   1      serializer accepts m_data this cycle
//  busy       out  1      high from first accepted byte until the IFG completes
//  frame_cnt  out  CNT_W  count of completed frames; wraps at 2^CNT_W
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state IDLE, crc=32'hFFFFFFFF, byte_cnt=0; s_ready, m_valid,
//    m_last, busy = 0; m_data = 8'h00; frame_cnt = 0. Reset mid-frame aborts the frame. No FCS
//    or partial output follows, and the next frame starts clean.
//  - Handshakes: a transfer occurs when valid&&ready at posedge. m_data, m_valid and m_last are
//    registered and stay stable while m_valid && !m_ready. s_ready = (state in IDLE/DATA) &&
//    (!m_valid || m_ready).
//  - Latency: an accepted s_data appears on m_data the next cycle.
//  - CRC: reflected poly 32'hEDB88320, init 32'hFFFFFFFF, one byte per accepted input (or pad)
//    byte. FCS = ~crc, sent LSB byte first (FCS[7:0] first).
//  - States:
//    IDLE: the first accept loads crc with step(FFFFFFFF, byte) and sets busy.
//      If s_last, go to FCS (or PAD); otherwise go to DATA.
//    DATA: each accept updates crc and increments byte_cnt (saturating at 2^CNT_W-1).
//      An accept with s_last goes to PAD if the pad condition holds, otherwise to FCS.
//    PAD: emit 8'h00 bytes, folding each into crc, until byte_cnt == MIN_PAYLOAD, then go to FCS.
//    FCS: emit 4 bytes, indexed by a 2-bit counter, each on an m handshake. The 4th byte has
//      m_last=1. On its transfer, frame_cnt++ and go to IFG.
//    IFG: count IFG_CYCLES cycles with s_ready=0 and m_valid=0, then busy=0 and go to IDLE.
//  - s_valid with s_last in the same cycle as the first byte is a legal 1-byte frame.
//  - m_ready low in the FCS or PAD state holds the byte index and the crc.
//  - s_valid is ignored outside IDLE/DATA; upstream must hold it.
// CONFIGURATION
//  ETH_FCS_PAD_EN defined: frames shorter than MIN_PAYLOAD bytes are zero-padded to
//    MIN_PAYLOAD before the FCS, and the pad bytes are included in the CRC.
//  ETH_FCS_PAD_EN undefined: the PAD state and its compare logic are absent. The FCS directly
//    follows s_last, whatever the length.
// STRUCTURE
//  Package eth_crc_pkg: CRC_POLY_REFL, CRC_INIT, CRC_RESIDUE (32'hDEBB20E3),
//    typedef enum fcs_state_t {IDLE, DATA, PAD, FCS, IFG}, function reflect8().
//  Sub-module crc32_byte_step: combinational, crc_in[31:0] + byte[7:0] -> crc_out[31:0].
//    It has 8 unrolled shift/xor stages. It is instanced once; its input is muxed between s_data
//    and 8'h00 (pad).
// TESTING
//  1) PAD off: "123456789" (8'h31..8'h39), m_ready=1 -> 9 bytes echoed, then 26 39 F4 CB
//     with m_last on CB; frame_cnt=1.
//  2) Random m_ready backpressure on test 1 -> identical byte sequence; m_data stable while
//     stalled.
//  3) PAD on, MIN_PAYLOAD=60, 1-byte frame 8'hAA -> AA, then 59x 00, then FCS.
//     CRC over all 64 output bytes equals CRC_RESIDUE.
//  4) Back-to-back frames -> exactly IFG_CYCLES cycles with s_ready=0 between m_last and the
//     next accept.
//  5) Assert rst during the DATA state of a 20-byte frame -> all outputs at reset values the
//     next cycle. A following frame gives the correct FCS; frame_cnt=1.

Source files
------------

// File: rtl/eth_crc_pkg.sv
// Shared CRC-32 constants, FCS sequencer state type and a byte bit-reversal helper.
package eth_crc_pkg;

    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    // Register value left after running a good frame, FCS included, through the CRC.
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PAD,
        FCS,
        IFG
    } fcs_state_t;

    // Bit-reverse a byte, for converting between MSB-first and wire-order views.
    function automatic logic [7:0] reflect8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_byte_step.sv
// One byte of the reflected CRC-32: eight shift/xor stages, purely combinational.
module crc32_byte_step
    import eth_crc_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    // Fold the byte into the low end, then shift one bit per stage (LSB first).
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
        crc_out = crc_in ^ {24'h0, data_in};
        for (int i = 0; i < 8; i++) begin
            crc_out = {1'b0, crc_out[31:1]} ^ (CRC_POLY_REFL & {32{crc_out[0]}});
        end
    end

endmodule

// File: rtl/eth_fcs_seq.sv
// Transmit FCS sequencer: forwards frame bytes, appends the CRC-32 FCS (LSB byte first),
// then holds off the next frame for the inter-frame gap.
// Build option: define ETH_FCS_PAD_EN to zero-pad short frames to MIN_PAYLOAD before the FCS.
module eth_fcs_seq
    import eth_crc_pkg::*;
#(
    parameter int IFG_CYCLES  = 12,
    parameter int MIN_PAYLOAD = 60,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [7:0]       m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int               IFG_W    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_CYCLES - 1);

    if (IFG_CYCLES < 1 || MIN_PAYLOAD < 1) begin : g_param_check
        $error("eth_fcs_seq: IFG_CYCLES and MIN_PAYLOAD must be at least 1");
    end

    fcs_state_t       state_q, state_d;
    logic [31:0]      crc_q, crc_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [1:0]       fcs_idx_q, fcs_idx_d;
    logic [IFG_W-1:0] ifg_cnt_q, ifg_cnt_d;
    logic [7:0]       m_data_q, m_data_d;
    logic             m_valid_q, m_valid_d;
    logic             m_last_q, m_last_d;
    logic             busy_q, busy_d;

    logic             slot_free;
    logic             s_accept;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] acc_cnt;
    logic [31:0]      fcs_val;
    logic [7:0]       step_byte;
    logic [31:0]      step_crc_in;
    logic [31:0]      step_crc_out;

    // The output register can take a new byte when empty or being drained this cycle.
    assign slot_free = !m_valid_q || m_ready;
    assign s_ready   = !rst && (state_q == IDLE || state_q == DATA) && slot_free;
    assign s_accept  = s_valid && s_ready;
    assign cnt_inc   = (byte_cnt_q == {CNT_W{1'b1}}) ? byte_cnt_q : byte_cnt_q + 1'b1;
    assign acc_cnt   = (state_q == IDLE) ? CNT_W'(1) : cnt_inc;
    assign fcs_val   = ~crc_q;

    // First byte of a frame starts from the init value; crc_q still holds the old frame's CRC.
    assign step_crc_in = (state_q == IDLE) ? CRC_INIT : crc_q;
`ifdef ETH_FCS_PAD_EN
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PAYLOAD);
    assign step_byte = (state_q == PAD) ? 8'h00 : s_data;
`else
    assign step_byte = s_data;
`endif

    crc32_byte_step u_crc_step (
        .crc_in  (step_crc_in),
        .data_in (step_byte),
        .crc_out (step_crc_out)
    );

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        byte_cnt_d  = byte_cnt_q;
        frame_cnt_d = frame_cnt_q;
        fcs_idx_d   = fcs_idx_q;
        ifg_cnt_d   = ifg_cnt_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        busy_d      = busy_q;

        // A byte taken by the serializer empties the register unless refilled below.
        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end

        unique case (state_q)
            IDLE, DATA: begin
                if (s_accept) begin
                    crc_d      = step_crc_out;
                    byte_cnt_d = acc_cnt;
                    m_data_d   = s_data;
                    m_valid_d  = 1'b1;
                    busy_d     = 1'b1;
                    if (s_last) begin
`ifdef ETH_FCS_PAD_EN
                        state_d = (acc_cnt < MIN_CNT) ? PAD : FCS;
`else
                        state_d = FCS;
`endif
                    end else begin
                        state_d = DATA;
                    end
                end
            end
`ifdef ETH_FCS_PAD_EN
            PAD: begin
                if (slot_free) begin
                    crc_d      = step_crc_out;
                    byte_cnt_d = cnt_inc;
                    m_data_d   = 8'h00;
                    m_valid_d  = 1'b1;
                    if (cnt_inc == MIN_CNT) begin
                        state_d = FCS;
                    end
                end
            end
`endif
            FCS: begin
                if (m_last_q) begin
                    // Final FCS byte is loaded; the frame ends when it is taken.
                    if (m_ready) begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                        fcs_idx_d   = 2'd0;
                        ifg_cnt_d   = '0;
                        state_d     = IFG;
                    end
                end else if (slot_free) begin
                    m_data_d  = fcs_val[{fcs_idx_q, 3'b000} +: 8];
                    m_valid_d = 1'b1;
                    m_last_d  = (fcs_idx_q == 2'd3);
                    fcs_idx_d = fcs_idx_q + 2'd1;
                end
            end
            IFG: begin
                if (ifg_cnt_q == IFG_LAST) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    ifg_cnt_d = ifg_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset; reset also aborts any frame in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            crc_q       <= CRC_INIT;
            byte_cnt_q  <= '0;
            frame_cnt_q <= '0;
            fcs_idx_q   <= 2'd0;
            ifg_cnt_q   <= '0;
            m_data_q    <= 8'h00;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            byte_cnt_q  <= byte_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            fcs_idx_q   <= fcs_idx_d;
            ifg_cnt_q   <= ifg_cnt_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            busy_q      <= busy_d;
        end
    end

    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_eth_fcs_seq.sv
// Scoreboard bench for eth_fcs_seq: expected output bytes are queued when a frame is
// scheduled and compared as the serializer side takes them.
`timescale 1ns/1ps
module tb_eth_fcs_seq;
    import eth_crc_pkg::*;

    localparam int IFG_CYCLES  = 12;
    localparam int MIN_PAYLOAD = 60;
    localparam int CNT_W       = 16;
    localparam int WAIT_LIMIT  = 4000;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       s_data;
    logic             s_valid;
    logic             s_last;
    logic             s_ready;
    logic [7:0]       m_data;
    logic             m_valid;
    logic             m_last;
    logic             m_ready;
    logic             busy;
    logic [CNT_W-1:0] frame_cnt;

    eth_fcs_seq #(
        .IFG_CYCLES  (IFG_CYCLES),
        .MIN_PAYLOAD (MIN_PAYLOAD),
        .CNT_W       (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   gap_checks = 0;
    bit   bp_mode = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Bit-serial reference CRC, one input bit per iteration.
    function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // Queue payload (plus pad when the build pads) and return the running CRC.
    function automatic logic [31:0] push_payload(input logic [7:0] bytes[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (bytes[i]) begin
            exp_q.push_back('{data: bytes[i], last: 1'b0});
            c = crc_model(c, bytes[i]);
        end
`ifdef ETH_FCS_PAD_EN
        for (int n = bytes.size(); n < MIN_PAYLOAD; n++) begin
            exp_q.push_back('{data: 8'h00, last: 1'b0});
            c = crc_model(c, 8'h00);
        end
`endif
        return c;
    endfunction

    function automatic void push_fcs(input logic [31:0] fcs);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back('{data: fcs[8*k +: 8], last: (k == 3)});
        end
    endfunction

    function automatic void push_frame(input logic [7:0] bytes[$]);
        logic [31:0] c;
        c = push_payload(bytes);
        push_fcs(~c);
    endfunction

    // Serializer-side backpressure, re-drawn every cycle.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = bp_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Output monitor: scoreboard compare, stall stability, FCS residue and IFG length.
    logic [31:0] mon_crc = 32'hFFFFFFFF;
    bit          stall_hold = 1'b0;
    logic [7:0]  stall_data;
    bit          gap_armed = 1'b0;
    int          gap_cnt = 0;
    exp_t        e;

    always @(negedge clk) begin
        if (rst) begin
            stall_hold = 1'b0;
            gap_armed  = 1'b0;
            mon_crc    = 32'hFFFFFFFF;
        end else begin
            if (stall_hold) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                check("stall_data", 32'(m_data), 32'(stall_data));
            end
            stall_hold = m_valid && !m_ready;
            stall_data = m_data;

            if (gap_armed) begin
                if (!s_ready) begin
                    gap_cnt++;
                end else begin
                    if (s_valid) begin
                        check("ifg_gap", 32'(gap_cnt), 32'(IFG_CYCLES));
                        gap_checks++;
                    end
                    gap_armed = 1'b0;
                end
            end

            if (m_valid && m_ready) begin
                check("exp_avail", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("m_data", 32'(m_data), 32'(e.data));
                    check("m_last", 32'(m_last), 32'(e.last));
                end
                mon_crc = crc_model(mon_crc, m_data);
                if (m_last) begin
                    check("residue", mon_crc, CRC_RESIDUE);
                    mon_crc   = 32'hFFFFFFFF;
                    gap_armed = 1'b1;
                    gap_cnt   = 0;
                end
            end
        end
    end

    // Present bytes one at a time; returns #1 after the edge that accepted the last one sent.
    task automatic send_frame(input logic [7:0] bytes[$], input int n_send);
        int t;
        for (int i = 0; i < n_send; i++) begin
            s_data  = bytes[i];
            s_valid = 1'b1;
            s_last  = (i == bytes.size() - 1);
            t = 0;
            forever begin
                @(negedge clk);
                if (s_ready) break;
                t++;
                if (t >= WAIT_LIMIT) begin
                    check("accept_timeout", 32'(s_ready), 32'd1);
                    break;
                end
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
            t++;
            if (t >= WAIT_LIMIT) begin
                check("drain_timeout", 32'(exp_q.size()), 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"},   32'(s_ready),   32'd0);
        check({tag, "_m_valid"},   32'(m_valid),   32'd0);
        check({tag, "_m_last"},    32'(m_last),    32'd0);
        check({tag, "_m_data"},    32'(m_data),    32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    endtask

    initial begin
        logic [7:0]  frm[$];
        logic [7:0]  frm_b[$];
        logic [31:0] c;

        rst     = 1'b1;
        s_data  = 8'h00;
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("idle_s_ready", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;

        // Test 1: check value frame "123456789".
        frm.delete();
        for (int i = 0; i < 9; i++) frm.push_back(8'h31 + 8'(i));
        c = push_payload(frm);
`ifdef ETH_FCS_PAD_EN
        push_fcs(~c);
`else
        push_fcs(32'hCBF43926);
`endif
        send_frame(frm, frm.size());
        wait_drain();
        check("t1_frame_cnt", 32'(frame_cnt), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);

        // Test 2: same frame under random backpressure.
        bp_mode = 1'b1;
        push_frame(frm);
        send_frame(frm, frm.size());
        wait_drain();
        check("t2_frame_cnt", 32'(frame_cnt), 32'd2);

        // Test 3: single-byte frame (padded to MIN_PAYLOAD when the build pads).
        bp_mode = 1'b0;
        frm.delete();
        frm.push_back(8'hAA);
        push_frame(frm);
        send_frame(frm, frm.size());
        wait_drain();
        check("t3_frame_cnt", 32'(frame_cnt), 32'd3);

        // Test 4: back-to-back frames, the second waits out the IFG.
        frm.delete();
        for (int i = 0; i < 5; i++) frm.push_back(8'($urandom_range(0, 255)));
        frm_b.delete();
        for (int i = 0; i < 3; i++) frm_b.push_back(8'($urandom_range(0, 255)));
        push_frame(frm);
        push_frame(frm_b);
        send_frame(frm, frm.size());
        send_frame(frm_b, frm_b.size());
        wait_drain();
        check("t4_frame_cnt", 32'(frame_cnt), 32'd5);
        check("t4_gap_seen", 32'(gap_checks > 0), 32'd1);

        // Test 5: reset in the middle of a 20-byte frame, then a clean frame.
        frm.delete();
        for (int i = 0; i < 20; i++) frm.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < 10; i++) exp_q.push_back('{data: frm[i], last: 1'b0});
        send_frame(frm, 10);
        check("t5_busy_mid", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("t5_reset");
        exp_q.delete();
        rst = 1'b0;
        @(posedge clk);
        #1;
        push_frame(frm);
        send_frame(frm, frm.size());
        wait_drain();
        check("t5_frame_cnt", 32'(frame_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
